// File: rtl/id_ex_stage_reg_if.sv
// ID/EX boundary bundle: decoded instruction fields in, registered EX copies,
// NZCV flags and bubble count out. The pipeline stage uses the slave side.
interface id_ex_stage_reg_if #(
  parameter int DW    = 32,
  parameter int CNT_W = 16
);
  logic             freeze;
  logic             flush;
  logic             hazard;

  logic [DW-1:0]    id_pc;
  logic [DW-1:0]    id_rn_val;
  logic [DW-1:0]    id_rm_val;
  logic             id_imm;
  logic [23:0]      id_signed_imm;
  logic [11:0]      id_shift_op;
  logic [3:0]       id_dest;
  logic [3:0]       id_src1;
  logic [3:0]       id_src2;
  logic             id_wb_en;
  logic             id_mem_r_en;
  logic             id_mem_w_en;
  logic             id_b;
  logic             id_s;
  logic [3:0]       id_exe_cmd;

  logic             ex_status_we;
  logic [3:0]       ex_status;

  logic [DW-1:0]    ex_pc;
  logic [DW-1:0]    ex_rn_val;
  logic [DW-1:0]    ex_rm_val;
  logic             ex_imm;
  logic [23:0]      ex_signed_imm;
  logic [11:0]      ex_shift_op;
  logic [3:0]       ex_dest;
  logic [3:0]       ex_src1;
  logic [3:0]       ex_src2;
  logic             ex_wb_en;
  logic             ex_mem_r_en;
  logic             ex_mem_w_en;
  logic             ex_b;
  logic             ex_s;
  logic [3:0]       ex_exe_cmd;
  logic             ex_valid;

  logic             sr_n;
  logic             sr_z;
  logic             sr_c;
  logic             sr_v;
  logic [CNT_W-1:0] bubble_cnt;

  modport master (
    output freeze, flush, hazard,
    output id_pc, id_rn_val, id_rm_val, id_imm, id_signed_imm, id_shift_op,
    output id_dest, id_src1, id_src2,
    output id_wb_en, id_mem_r_en, id_mem_w_en, id_b, id_s, id_exe_cmd,
    output ex_status_we, ex_status,
    input  ex_pc, ex_rn_val, ex_rm_val, ex_imm, ex_signed_imm, ex_shift_op,
    input  ex_dest, ex_src1, ex_src2,
    input  ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_b, ex_s, ex_exe_cmd, ex_valid,
    input  sr_n, sr_z, sr_c, sr_v, bubble_cnt
  );

  modport slave (
    input  freeze, flush, hazard,
    input  id_pc, id_rn_val, id_rm_val, id_imm, id_signed_imm, id_shift_op,
    input  id_dest, id_src1, id_src2,
    input  id_wb_en, id_mem_r_en, id_mem_w_en, id_b, id_s, id_exe_cmd,
    input  ex_status_we, ex_status,
    output ex_pc, ex_rn_val, ex_rm_val, ex_imm, ex_signed_imm, ex_shift_op,
    output ex_dest, ex_src1, ex_src2,
    output ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_b, ex_s, ex_exe_cmd, ex_valid,
    output sr_n, sr_z, sr_c, sr_v, bubble_cnt
  );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with bubble insertion, freeze hold and the NZCV status register.
// Latency 1 cycle, all outputs are flops; freeze holds the pipeline but never the status flags.
module id_ex_stage_reg #(
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input logic               clk,
  input logic               rst,
  id_ex_stage_reg_if.slave  bus
);

  typedef struct packed {
    logic [DW-1:0] pc;
    logic [DW-1:0] rn_val;
    logic [DW-1:0] rm_val;
    logic          imm;
    logic [23:0]   signed_imm;
    logic [11:0]   shift_op;
    logic [3:0]    dest;
    logic [3:0]    src1;
    logic [3:0]    src2;
    logic          wb_en;
    logic          mem_r_en;
    logic          mem_w_en;
    logic          b;
    logic          s;
    logic [3:0]    exe_cmd;
  } pipe_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  pipe_t            id_pipe;
  pipe_t            pipe_d, pipe_q;
  logic             valid_d, valid_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [3:0]       sr_d, sr_q;
  logic             bubble;

  always_comb begin
    id_pipe            = '0;
    id_pipe.pc         = bus.id_pc;
    id_pipe.rn_val     = bus.id_rn_val;
    id_pipe.rm_val     = bus.id_rm_val;
    id_pipe.imm        = bus.id_imm;
    id_pipe.signed_imm = bus.id_signed_imm;
    id_pipe.shift_op   = bus.id_shift_op;
    id_pipe.dest       = bus.id_dest;
    id_pipe.src1       = bus.id_src1;
    id_pipe.src2       = bus.id_src2;
    id_pipe.wb_en      = bus.id_wb_en;
    id_pipe.mem_r_en   = bus.id_mem_r_en;
    id_pipe.mem_w_en   = bus.id_mem_w_en;
    id_pipe.b          = bus.id_b;
    id_pipe.s          = bus.id_s;
    id_pipe.exe_cmd    = bus.id_exe_cmd;
  end

  // flush and hazard collapse into one bubble so a coincident pair counts once
  assign bubble = bus.flush | bus.hazard;

  always_comb begin
    pipe_d  = pipe_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (!bus.freeze) begin
      if (bubble) begin
        pipe_d  = '0;
        valid_d = 1'b0;
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end else begin
        pipe_d  = id_pipe;
        valid_d = 1'b1;
      end
    end
  end

  // EX already qualifies the write enable, so the flags ignore freeze/flush/hazard
  always_comb begin
    sr_d = sr_q;
    if (bus.ex_status_we) begin
      sr_d = bus.ex_status;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      sr_q    <= '0;
    end else begin
      pipe_q  <= pipe_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
    end
  end

  assign bus.ex_pc         = pipe_q.pc;
  assign bus.ex_rn_val     = pipe_q.rn_val;
  assign bus.ex_rm_val     = pipe_q.rm_val;
  assign bus.ex_imm        = pipe_q.imm;
  assign bus.ex_signed_imm = pipe_q.signed_imm;
  assign bus.ex_shift_op   = pipe_q.shift_op;
  assign bus.ex_dest       = pipe_q.dest;
  assign bus.ex_src1       = pipe_q.src1;
  assign bus.ex_src2       = pipe_q.src2;
  assign bus.ex_wb_en      = pipe_q.wb_en;
  assign bus.ex_mem_r_en   = pipe_q.mem_r_en;
  assign bus.ex_mem_w_en   = pipe_q.mem_w_en;
  assign bus.ex_b          = pipe_q.b;
  assign bus.ex_s          = pipe_q.s;
  assign bus.ex_exe_cmd    = pipe_q.exe_cmd;
  assign bus.ex_valid      = valid_q;

  assign bus.sr_n          = sr_q[3];
  assign bus.sr_z          = sr_q[2];
  assign bus.sr_c          = sr_q[1];
  assign bus.sr_v          = sr_q[0];
  assign bus.bubble_cnt    = cnt_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Scoreboarded bench for id_ex_stage_reg: a 16-bit-counter instance and a 4-bit-counter
// instance see identical stimulus; a monitor compares both after every rising edge.
module tb_id_ex_stage_reg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rn;
    logic [31:0] rm;
    logic        imm;
    logic [23:0] simm;
    logic [11:0] sh;
    logic [3:0]  dest;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic        wb;
    logic        mr;
    logic        mw;
    logic        b;
    logic        s;
    logic [3:0]  cmd;
  } pay_t;

  typedef struct packed {
    pay_t       p;
    logic       frz;
    logic       fl;
    logic       hz;
    logic       swe;
    logic [3:0] st;
  } stim_t;

  typedef struct packed {
    pay_t        p;
    logic        valid;
    logic [3:0]  sr;
    logic [15:0] cnt;
    logic [3:0]  cnt4;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  id_ex_stage_reg_if #(.DW(32), .CNT_W(16)) bus ();
  id_ex_stage_reg_if #(.DW(32), .CNT_W(4))  bus4 ();

  id_ex_stage_reg #(.DW(32), .CNT_W(16)) dut     (.clk(clk), .rst(rst), .bus(bus));
  id_ex_stage_reg #(.DW(32), .CNT_W(4))  dut_sat (.clk(clk), .rst(rst), .bus(bus4));

  assign bus4.freeze        = bus.freeze;
  assign bus4.flush         = bus.flush;
  assign bus4.hazard        = bus.hazard;
  assign bus4.id_pc         = bus.id_pc;
  assign bus4.id_rn_val     = bus.id_rn_val;
  assign bus4.id_rm_val     = bus.id_rm_val;
  assign bus4.id_imm        = bus.id_imm;
  assign bus4.id_signed_imm = bus.id_signed_imm;
  assign bus4.id_shift_op   = bus.id_shift_op;
  assign bus4.id_dest       = bus.id_dest;
  assign bus4.id_src1       = bus.id_src1;
  assign bus4.id_src2       = bus.id_src2;
  assign bus4.id_wb_en      = bus.id_wb_en;
  assign bus4.id_mem_r_en   = bus.id_mem_r_en;
  assign bus4.id_mem_w_en   = bus.id_mem_w_en;
  assign bus4.id_b          = bus.id_b;
  assign bus4.id_s          = bus.id_s;
  assign bus4.id_exe_cmd    = bus.id_exe_cmd;
  assign bus4.ex_status_we  = bus.ex_status_we;
  assign bus4.ex_status     = bus.ex_status;

  int   checks = 0;
  int   errors = 0;
  exp_t m;
  exp_t sb[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare(input exp_t e, input string tag);
    chk({tag, ".pc"},      bus.ex_pc,         e.p.pc);
    chk({tag, ".rn"},      bus.ex_rn_val,     e.p.rn);
    chk({tag, ".rm"},      bus.ex_rm_val,     e.p.rm);
    chk({tag, ".imm"},     bus.ex_imm,        e.p.imm);
    chk({tag, ".simm"},    bus.ex_signed_imm, e.p.simm);
    chk({tag, ".shift"},   bus.ex_shift_op,   e.p.sh);
    chk({tag, ".dest"},    bus.ex_dest,       e.p.dest);
    chk({tag, ".src1"},    bus.ex_src1,       e.p.src1);
    chk({tag, ".src2"},    bus.ex_src2,       e.p.src2);
    chk({tag, ".ctl"}, {bus.ex_wb_en, bus.ex_mem_r_en, bus.ex_mem_w_en, bus.ex_b, bus.ex_s},
        {e.p.wb, e.p.mr, e.p.mw, e.p.b, e.p.s});
    chk({tag, ".cmd"},     bus.ex_exe_cmd,    e.p.cmd);
    chk({tag, ".valid"},   bus.ex_valid,      e.valid);
    chk({tag, ".nzcv"}, {bus.sr_n, bus.sr_z, bus.sr_c, bus.sr_v}, e.sr);
    chk({tag, ".cnt"},     bus.bubble_cnt,    e.cnt);
    chk({tag, ".cnt4"},    bus4.bubble_cnt,   e.cnt4);
    chk({tag, ".valid4"},  bus4.ex_valid,     e.valid);
  endtask

  task automatic drive(input stim_t s);
    bus.id_pc         = s.p.pc;
    bus.id_rn_val     = s.p.rn;
    bus.id_rm_val     = s.p.rm;
    bus.id_imm        = s.p.imm;
    bus.id_signed_imm = s.p.simm;
    bus.id_shift_op   = s.p.sh;
    bus.id_dest       = s.p.dest;
    bus.id_src1       = s.p.src1;
    bus.id_src2       = s.p.src2;
    bus.id_wb_en      = s.p.wb;
    bus.id_mem_r_en   = s.p.mr;
    bus.id_mem_w_en   = s.p.mw;
    bus.id_b          = s.p.b;
    bus.id_s          = s.p.s;
    bus.id_exe_cmd    = s.p.cmd;
    bus.freeze        = s.frz;
    bus.flush         = s.fl;
    bus.hazard        = s.hz;
    bus.ex_status_we  = s.swe;
    bus.ex_status     = s.st;
  endtask

  // Called at a falling edge: drives, predicts the next edge, returns at the following falling edge.
  task automatic issue(input stim_t s);
    drive(s);
    if (!s.frz) begin
      if (s.fl || s.hz) begin
        m.p     = '0;
        m.valid = 1'b0;
        if (m.cnt != 16'hFFFF) m.cnt = m.cnt + 16'd1;
        if (m.cnt4 != 4'hF)    m.cnt4 = m.cnt4 + 4'd1;
      end else begin
        m.p     = s.p;
        m.valid = 1'b1;
      end
    end
    if (s.swe) m.sr = s.st;
    sb.push_back(m);
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        compare(e, "edge");
      end
    end
  end

  initial begin : stim
    stim_t s;
    stim_t busy;
    m = '0;
    s = '0;
    drive(s);
    #1 rst = 1'b0;
    @(negedge clk);
    compare(m, "por");

    // release, then first load
    rst = 1'b1;
    s = '0; s.p.pc = 32'h4; s.p.cmd = 4'b0010;
    issue(s);
    chk("first_pc", bus.ex_pc, 64'h4);
    chk("first_cmd", bus.ex_exe_cmd, 64'h2);
    chk("first_valid", bus.ex_valid, 64'h1);

    for (int i = 0; i < 4; i++) begin
      s = '0;
      s.p.pc   = 32'h100 + 32'(i * 4);
      s.p.rn   = 32'h1111_0000 ^ (32'h0F0F_0F0F << i);
      s.p.rm   = ~s.p.rn;
      s.p.imm  = i[0];
      s.p.simm = 24'hA5_0000 | 24'(i);
      s.p.sh   = 12'hFFF >> i;
      s.p.dest = 4'(i + 1);
      s.p.src1 = 4'(15 - i);
      s.p.src2 = 4'(i * 3);
      {s.p.wb, s.p.mr, s.p.mw, s.p.b, s.p.s} = 5'b1_0000 >> i;
      s.p.cmd  = 4'(i + 9);
      issue(s);
    end

    // load-use hazard bubble
    s = '0; s.p.wb = 1'b1; s.p.mr = 1'b1; s.p.pc = 32'h200; s.hz = 1'b1;
    issue(s);
    chk("hz_wb", bus.ex_wb_en, 64'h0);
    chk("hz_mr", bus.ex_mem_r_en, 64'h0);
    chk("hz_valid", bus.ex_valid, 64'h0);
    chk("hz_cnt", bus.bubble_cnt, 64'h1);
    s.hz = 1'b0;
    issue(s);
    chk("hz_reload_valid", bus.ex_valid, 64'h1);
    chk("hz_reload_pc", bus.ex_pc, 64'h200);

    // freeze beats flush and hazard
    s = '0; s.p.rn = 32'hDEAD_BEEF; s.p.pc = 32'h300;
    issue(s);
    s = '0; s.p.rn = 32'h1234_5678; s.frz = 1'b1; s.fl = 1'b1; s.hz = 1'b1;
    repeat (3) issue(s);
    chk("frz_rn", bus.ex_rn_val, 64'hDEAD_BEEF);
    chk("frz_valid", bus.ex_valid, 64'h1);
    chk("frz_cnt", bus.bubble_cnt, 64'h1);

    // coincident flush and hazard count once
    s = '0; s.p.pc = 32'h400; s.fl = 1'b1; s.hz = 1'b1;
    issue(s);
    chk("both_cnt", bus.bubble_cnt, 64'h2);
    chk("both_valid", bus.ex_valid, 64'h0);

    // status register
    s = '0; s.p.pc = 32'h500; s.swe = 1'b1; s.st = 4'b0110;
    issue(s);
    chk("sr_write", {bus.sr_n, bus.sr_z, bus.sr_c, bus.sr_v}, 64'b0110);
    s.swe = 1'b0; s.st = 4'b1111;
    issue(s);
    chk("sr_hold", {bus.sr_n, bus.sr_z, bus.sr_c, bus.sr_v}, 64'b0110);
    s.swe = 1'b1; s.st = 4'b1001; s.frz = 1'b1;
    issue(s);
    chk("sr_frz", {bus.sr_n, bus.sr_z, bus.sr_c, bus.sr_v}, 64'b1001);

    s = '0; s.fl = 1'b1;
    issue(s);
    chk("flush_cnt", bus.bubble_cnt, 64'h3);

    // saturation of the narrow counter
    s = '0; s.hz = 1'b1;
    repeat (20) issue(s);
    chk("sat_cnt4", bus4.bubble_cnt, 64'hF);
    chk("wide_cnt", bus.bubble_cnt, 64'd23);
    issue(s);
    chk("sat_cnt4_hold", bus4.bubble_cnt, 64'hF);

    // reset in the middle of a freeze clears everything at once
    s = '0; s.p.pc = 32'h600; s.p.rn = 32'hCAFE_F00D; s.p.wb = 1'b1; s.p.cmd = 4'hC;
    issue(s);
    busy = s; busy.frz = 1'b1; busy.hz = 1'b1; busy.swe = 1'b1; busy.st = 4'hF;
    drive(busy);
    #2 rst = 1'b0;
    #1;
    m = '0;
    compare(m, "arst");
    @(negedge clk);
    compare(m, "arst_hold");
    rst = 1'b1;
    s = '0; s.p.pc = 32'h4; s.p.cmd = 4'b0010;
    issue(s);
    chk("post_rst_pc", bus.ex_pc, 64'h4);
    chk("post_rst_valid", bus.ex_valid, 64'h1);
    chk("post_rst_cnt", bus.bubble_cnt, 64'h0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- Pipeline register between the instruction-decode stage and the execute stage of the 5-stage ARM core.
- Captures decoded operands, immediates and control signals each cycle.
- Inserts bubbles on a load-use hazard or a taken branch, and holds its contents on a global memory freeze.
- Also owns the NZCV status register: it is written from the execute stage and read back by decode for condition evaluation.

Parameters:
- DW, 32, datapath width (PC, Rn, Rm values).
- CNT_W, 16, width of the saturating bubble counter.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset, asynchronous, active-low. All state clears while low.
- freeze  input  1  global memory stall. Holds all pipeline state.
- flush  input  1  branch taken in EX. Squashes the instruction entering EX.
- hazard  input  1  load-use hazard from the hazard unit. Inserts a bubble.
- id_pc  input  DW  PC+4 of the decoded instruction.
- id_rn_val, id_rm_val  input  DW  register-file read values.
- id_imm  input  1  immediate-operand flag.
- id_signed_imm  input  24  branch offset.
- id_shift_op  input  12  shifter operand field.
- id_dest, id_src1, id_src2  input  4  register numbers.
- id_wb_en, id_mem_r_en, id_mem_w_en, id_b, id_s  input  1  control bits.
- id_exe_cmd  input  4  ALU command.
- ex_status_we  input  1  status write enable (S-bit of the instruction in EX, already qualified).
- ex_status  input  4  new {N,Z,C,V} from the ALU.
- ex_* (one output per id_* input, same widths)  output  registered copies.
- ex_valid  output  1  the instruction held in EX is real (not a bubble).
- sr_n, sr_z, sr_c, sr_v  output  1  current status flags, to decode.
- bubble_cnt  output  CNT_W  number of bubbles inserted.

Behaviour:
- Reset (rst=0, asynchronous): every ex_* output, ex_valid, all four status flags and bubble_cnt go to 0 immediately, without waiting for a clock edge. State stays cleared until the first rising edge after rst returns to 1.
- Latency: 1 cycle. Inputs sampled at a rising edge appear on ex_* right after that edge.
- Per rising edge, with priority from highest to lowest:
  1. freeze=1: HOLD. All ex_* outputs, ex_valid and bubble_cnt keep their values, even if flush or hazard is asserted.
  2. flush=1: BUBBLE. ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_b, ex_s, ex_exe_cmd and ex_valid go to 0. Data fields (pc, values, imm fields, register numbers) also go to 0. bubble_cnt increments.
  3. hazard=1: BUBBLE, identical to flush. When flush and hazard are both 1, only one increment occurs.
  4. Otherwise: LOAD. All id_* inputs are captured and ex_valid=1.
- Bubble counter: unsigned, saturates at 2^CNT_W-1 and does not wrap. Cleared only by reset.
- Status register:
  - On a rising edge with ex_status_we=1, {sr_n,sr_z,sr_c,sr_v} <= ex_status.
  - This update is independent of freeze, flush and hazard, because EX qualifies ex_status_we itself.
  - With ex_status_we=0 the flags hold.
  - No write-through: decode sees the new flags one cycle after the write edge.
- No combinational path from any input to any output. Every output is a flop.
- Reset asserted mid-operation (including during freeze) overrides everything. The first edge after release behaves as a normal LOAD/BUBBLE/HOLD decision.

Test Plan:
- Reset: drive nonzero inputs, rst=0 between clock edges -> all outputs 0 immediately; release, next edge with id_pc=32'h4, id_exe_cmd=4'b0010 -> ex_pc=32'h4, ex_exe_cmd=4'b0010, ex_valid=1.
- Hazard bubble: id_wb_en=1, id_mem_r_en=1, hazard=1 for one edge -> ex_wb_en=0, ex_mem_r_en=0, ex_valid=0, bubble_cnt=1; next edge with hazard=0 -> inputs loaded, ex_valid=1.
- Freeze priority: load id_rn_val=32'hDEAD_BEEF, then freeze=1 with flush=1 and hazard=1 for 3 edges -> ex_rn_val stays 32'hDEAD_BEEF, ex_valid stays 1, bubble_cnt unchanged.
- Simultaneous flush+hazard: both 1 for one edge -> single bubble, bubble_cnt increments by exactly 1.
- Status register: ex_status_we=1, ex_status=4'b0110 -> after the edge sr_z=1, sr_c=1, sr_n=0, sr_v=0; ex_status_we=0 with ex_status=4'b1111 -> flags unchanged; ex_status_we=1 during freeze=1 -> flags still update.
- Saturation (CNT_W=4 override): 20 consecutive hazard edges -> bubble_cnt=15 and stays at 15.
